ucie_ctl_sb_rx_assembler: RTL and testbench

- Receive-side sideband front end between the RDI config interface and the sideband decode logic.
- Collects NC-bit beats from the RDI into complete 64-bit-header (+ optional 64-bit data) messages and checks control/data parity and opcode.
- Presents each good message on a valid/ready output.
- Manages the RDI credit return (`o_cfg_crd`) so the physical layer never overruns local storage.

---
 rtl/ucie_ctl_sb_rx_assembler.sv | 205 ++++++++++++++++++++
 tb/tb_ucie_ctl_sb_rx_assembler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_rx_assembler.sv
// ucie_ctl_sb_rx_assembler
// Receive-side sideband front end. RDI beats (NC bits each) are collected
// into a 64-bit header plus an optional 64-bit data word. Each complete
// message has its opcode and CP/DP parity checked. A good message goes out
// on a valid/ready register. A bad one is dropped with an error pulse.
// Beat credits go back to the PHY once a message is consumed or dropped.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_pl_cfg_vld         RDI beat valid
//   i_received_data      RDI beat payload (header beats first, low bits first)
//   o_cfg_crd            one-cycle pulse per beat credit returned
//   o_msg_vld/i_msg_rdy  assembled message handshake
//   o_msg_hdr/o_msg_data message contents (data is 0 for header-only messages)
//   o_msg_has_data       message carried a data word
//   o_parity_err         pulse: message dropped for CP/DP mismatch
//   o_opcode_err         pulse: message dropped for unsupported opcode
//   o_crd_overflow       sticky: beat arrived with no credit outstanding
module ucie_ctl_sb_rx_assembler #(
    parameter int NC      = 32,
    parameter int CRD_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pl_cfg_vld,
    input  logic [NC-1:0] i_received_data,
    output logic          o_cfg_crd,
    output logic          o_msg_vld,
    input  logic          i_msg_rdy,
    output logic [63:0]   o_msg_hdr,
    output logic [63:0]   o_msg_data,
    output logic          o_msg_has_data,
    output logic          o_parity_err,
    output logic          o_opcode_err,
    output logic          o_crd_overflow
);
    localparam int BPW = 64 / NC;
    localparam int MB  = 2 * BPW;
    localparam int KW  = $clog2(MB);
    localparam int SW  = $clog2(MB + 1);
    localparam int CW  = $clog2(CRD_MAX + 1) + 1;

    localparam logic [KW-1:0] K_HLAST = KW'(BPW - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(MB - 1);
    localparam logic [CW-1:0] C_BPW   = CW'(BPW);
    localparam logic [CW-1:0] C_MB    = CW'(MB);
    localparam logic [CW-1:0] C_MAX   = CW'(CRD_MAX);
    localparam logic [4:0]    OP_NODATA = 5'b10010;
    localparam logic [4:0]    OP_DATA   = 5'b11011;

    typedef enum logic [1:0] {COLLECT, CHECK, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [MB-1:0][NC-1:0]   beats_q, beats_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    hd_q, hd_d;

    logic [NC-1:0]           skid_mem [MB];
    logic [KW-1:0]           wr_q, rd_q;
    logic [SW-1:0]           cnt_q;

    logic                    out_vld_q, out_hd_q;
    logic [63:0]             out_hdr_q, out_data_q;
    logic [CW-1:0]           pend_q, pend_d, outst_q;
    logic                    perr_q, perr_d, oerr_q, oerr_d, ovf_q;

    logic          crd, accept, skid_ne, in_col, col_vld, push, pop;
    logic          drain, out_free, load;
    logic [NC-1:0] col_beat;
    logic [4:0]    dec_op;
    logic [63:0]   hdr_w, data_w;
    logic          op_bad, cp_bad, dp_bad;
    logic [CW-1:0] err_add;

    assign crd     = (pend_q != '0);
    // The credit returned this cycle already frees a slot for a new beat.
    assign accept  = i_pl_cfg_vld && ((outst_q - CW'(crd)) != C_MAX);
    assign skid_ne = (cnt_q != '0);
    assign in_col  = (state_q == COLLECT);
    // Buffered beats are older than the incoming one, so they are replayed first.
    assign col_vld  = in_col && (skid_ne || accept);
    assign col_beat = skid_ne ? skid_mem[rd_q] : i_received_data;
    assign push     = accept && (!in_col || skid_ne);
    assign pop      = in_col && skid_ne;

    assign hdr_w  = beats_q[BPW-1:0];
    assign data_w = beats_q[MB-1:BPW];
    // With 64-bit beats the opcode arrives on the same beat that is decoded.
    assign dec_op = (k_q == '0) ? col_beat[4:0] : beats_q[0][4:0];

    assign op_bad = (hdr_w[4:0] != OP_NODATA) && (hdr_w[4:0] != OP_DATA);
    assign cp_bad = hdr_w[63] != ^hdr_w[62:0];
    assign dp_bad = hdr_w[62] != (hd_q ? ^data_w : 1'b0);

    assign drain    = out_vld_q && i_msg_rdy;
    assign out_free = !out_vld_q || drain;

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        k_d     = k_q;
        hd_d    = hd_q;
        load    = 1'b0;
        err_add = '0;
        perr_d  = 1'b0;
        oerr_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (col_vld) begin
                    beats_d[k_q] = col_beat;
                    k_d          = k_q + 1'b1;
                    if (k_q == K_HLAST) begin
                        // Unsupported opcodes are treated as header-only.
                        if (dec_op == OP_DATA) begin
                            hd_d = 1'b1;
                        end else begin
                            hd_d    = 1'b0;
                            k_d     = '0;
                            state_d = CHECK;
                        end
                    end else if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (op_bad || cp_bad || dp_bad) begin
                    oerr_d  = op_bad;
                    perr_d  = !op_bad;
                    err_add = hd_q ? C_MB : C_BPW;
                    state_d = COLLECT;
                end else if (out_free) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        pend_d = pend_q + (drain ? (out_hd_q ? C_MB : C_BPW) : '0) + err_add - CW'(crd);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= COLLECT;
            beats_q    <= '0;
            k_q        <= '0;
            hd_q       <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_hd_q   <= 1'b0;
            out_hdr_q  <= '0;
            out_data_q <= '0;
            pend_q     <= '0;
            outst_q    <= '0;
            perr_q     <= 1'b0;
            oerr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            k_q     <= k_d;
            hd_q    <= hd_d;
            wr_q    <= wr_q + KW'(push);
            rd_q    <= rd_q + KW'(pop);
            cnt_q   <= cnt_q + SW'(push) - SW'(pop);
            if (load) begin
                out_vld_q  <= 1'b1;
                out_hd_q   <= hd_q;
                out_hdr_q  <= hdr_w;
                out_data_q <= hd_q ? data_w : '0;
            end else if (drain) begin
                out_vld_q <= 1'b0;
            end
            pend_q  <= pend_d;
            outst_q <= outst_q + CW'(accept) - CW'(crd);
            perr_q  <= perr_d;
            oerr_q  <= oerr_d;
            if (i_pl_cfg_vld && !accept) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) skid_mem[wr_q] <= i_received_data;
    end

    assign o_cfg_crd      = crd;
    assign o_msg_vld      = out_vld_q;
    assign o_msg_hdr      = out_hdr_q;
    assign o_msg_data     = out_data_q;
    assign o_msg_has_data = out_hd_q;
    assign o_parity_err   = perr_q;
    assign o_opcode_err   = oerr_q;
    assign o_crd_overflow = ovf_q;
endmodule

// File: tb/tb_ucie_ctl_sb_rx_assembler.sv
module tb_ucie_ctl_sb_rx_assembler;
    localparam int NC      = 32;
    localparam int CRD_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_vld = 1'b0;
    logic [NC-1:0] rx_data = '0;
    logic          cfg_crd, msg_vld, msg_has_data, parity_err, opcode_err, crd_ovf;
    logic          msg_rdy = 1'b0;
    logic [63:0]   msg_hdr, msg_data;

    ucie_ctl_sb_rx_assembler #(.NC(NC), .CRD_MAX(CRD_MAX)) dut (
        .i_clk(clk), .i_rst(rst), .i_pl_cfg_vld(cfg_vld), .i_received_data(rx_data),
        .o_cfg_crd(cfg_crd), .o_msg_vld(msg_vld), .i_msg_rdy(msg_rdy),
        .o_msg_hdr(msg_hdr), .o_msg_data(msg_data), .o_msg_has_data(msg_has_data),
        .o_parity_err(parity_err), .o_opcode_err(opcode_err), .o_crd_overflow(crd_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // Reference model state: messages expected in order, plus counters.
    logic [63:0] exp_hdr_q[$], exp_data_q[$];
    bit          exp_hd_q[$];
    int exp_beats = 0, exp_perr = 0, exp_oerr = 0;
    int crd_seen = 0, perr_seen = 0, oerr_seen = 0, hs_seen = 0;
    int phy_crd = CRD_MAX;
    bit rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: count pulses and score every delivered message.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_crd) begin crd_seen++; phy_crd++; end
            if (parity_err) perr_seen++;
            if (opcode_err) oerr_seen++;
            if (parity_err && opcode_err) chk("double_err_pulse", 1, 0);
            if (msg_vld && msg_rdy) begin
                hs_seen++;
                if (exp_hdr_q.size() == 0) begin
                    chk("unexpected_msg", msg_hdr, 64'hx);
                end else begin
                    chk("msg_hdr", msg_hdr, exp_hdr_q.pop_front());
                    chk("msg_data", msg_data, exp_data_q.pop_front());
                    chk("msg_has_data", {63'd0, msg_has_data}, {63'd0, exp_hd_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Honour PHY credits like a real sender.
    task automatic drive_beat(input logic [NC-1:0] b);
        int guard = 0;
        while (phy_crd <= 0 && guard < 500) begin
            if (rand_mode) msg_rdy = 1'b1;
            tick(); guard++;
        end
        if (guard >= 500) chk("credit_wait_timeout", 1, 0);
        if (rand_mode) msg_rdy = 1'($urandom_range(0, 1));
        cfg_vld = 1'b1; rx_data = b; phy_crd--;
        tick();
        cfg_vld = 1'b0;
    endtask

    // Behavioural reference: classify the message from the header rules, then send it.
    task automatic send_msg(input logic [63:0] hdr, input logic [63:0] data);
        logic [4:0] op;
        bit wd, cp_ok, dp_ok;
        op    = hdr[4:0];
        wd    = (op == 5'h1B);
        cp_ok = (hdr[63] == ^hdr[62:0]);
        dp_ok = (hdr[62] == (wd ? ^data : 1'b0));
        if (op != 5'h12 && op != 5'h1B) exp_oerr++;
        else if (!(cp_ok && dp_ok)) exp_perr++;
        else begin
            exp_hdr_q.push_back(hdr);
            exp_data_q.push_back(wd ? data : 64'd0);
            exp_hd_q.push_back(wd);
        end
        exp_beats += wd ? 4 : 2;
        drive_beat(hdr[31:0]);
        drive_beat(hdr[63:32]);
        if (wd) begin
            drive_beat(data[31:0]);
            drive_beat(data[63:32]);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [63:0] data,
                                           input bit flip_cp, input bit flip_dp);
        logic [63:0] h;
        h       = {$urandom, $urandom};
        h[4:0]  = op;
        h[62]   = ((op == 5'h1B) ? ^data : 1'b0) ^ flip_dp;
        h[63]   = (^h[62:0]) ^ flip_cp;
        return h;
    endfunction

    task automatic do_reset();
        rst = 1'b1; cfg_vld = 1'b0;
        tick();
        rst = 1'b0;
        exp_hdr_q.delete(); exp_data_q.delete(); exp_hd_q.delete();
        exp_beats = 0; exp_perr = 0; exp_oerr = 0;
        crd_seen = 0; perr_seen = 0; oerr_seen = 0; hs_seen = 0;
        phy_crd = CRD_MAX;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_crd"}, {63'd0, cfg_crd}, 64'd0);
        chk({tag, "_vld"}, {63'd0, msg_vld}, 64'd0);
        chk({tag, "_hdr"}, msg_hdr, 64'd0);
        chk({tag, "_data"}, msg_data, 64'd0);
        chk({tag, "_errs"}, {62'd0, parity_err, opcode_err}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, crd_ovf}, 64'd0);
    endtask

    initial begin
        int c0, h0;
        logic [63:0] d, h;
        int kind;

        do_reset();
        check_idle_outputs("reset");

        // Header-only message, opcode 0x12, CP=1 is correct for 0x32 low byte.
        msg_rdy = 1'b1;
        c0 = crd_seen;
        send_msg(64'h80000000_00000032, 64'd0);
        @(negedge clk);
        chk("lat_not_yet", {63'd0, msg_vld}, 64'd0);
        @(negedge clk);
        chk("lat_vld", {63'd0, msg_vld}, 64'd1);
        chk("lat_hdr", msg_hdr, 64'h80000000_00000032);
        chk("lat_has_data", {63'd0, msg_has_data}, 64'd0);
        repeat (6) tick();
        chk("nodata_crd", 64'(crd_seen - c0), 64'd2);

        // Data message, data=1, DP=1 and CP over 0x1B + DP bit = 1.
        c0 = crd_seen;
        send_msg(64'hC0000000_0000001B, 64'd1);
        repeat (2) @(negedge clk);
        chk("data_vld", {63'd0, msg_vld}, 64'd1);
        chk("data_data", msg_data, 64'd1);
        chk("data_has_data", {63'd0, msg_has_data}, 64'd1);
        repeat (8) tick();
        chk("data_crd", 64'(crd_seen - c0), 64'd4);

        // CP flipped, then unsupported opcode.
        c0 = crd_seen; h0 = hs_seen;
        send_msg(64'h00000000_00000032, 64'd0);
        repeat (8) tick();
        chk("cp_perr_pulses", 64'(perr_seen), 64'd1);
        chk("cp_crd", 64'(crd_seen - c0), 64'd2);
        c0 = crd_seen;
        send_msg(mk_hdr(5'h05, 64'd0, 1'b0, 1'b0), 64'd0);
        repeat (8) tick();
        chk("op_oerr_pulses", 64'(oerr_seen), 64'd1);
        chk("op_crd", 64'(crd_seen - c0), 64'd2);
        chk("err_no_msg", 64'(hs_seen - h0), 64'd0);

        // Backpressure: one held, one buffered, then an uncredited beat.
        msg_rdy = 1'b0;
        c0 = crd_seen; h0 = hs_seen;
        send_msg(mk_hdr(5'h12, 64'd0, 1'b0, 1'b0), 64'd0);
        send_msg(mk_hdr(5'h12, 64'd0, 1'b0, 1'b0), 64'd0);
        repeat (4) tick();
        chk("bp_no_crd", 64'(crd_seen - c0), 64'd0);
        chk("bp_held_vld", {63'd0, msg_vld}, 64'd1);
        chk("bp_held_hdr", msg_hdr, exp_hdr_q[0]);
        cfg_vld = 1'b1; rx_data = 32'hDEAD_BEEF;
        tick();
        cfg_vld = 1'b0;
        @(negedge clk);
        chk("bp_overflow", {63'd0, crd_ovf}, 64'd1);
        tick();
        msg_rdy = 1'b1;
        repeat (12) tick();
        chk("bp_delivered", 64'(hs_seen - h0), 64'd2);
        chk("bp_crd", 64'(crd_seen - c0), 64'd4);
        chk("bp_queue_empty", 64'(exp_hdr_q.size()), 64'd0);

        // Reset in the middle of a data message.
        h = mk_hdr(5'h1B, 64'h5, 1'b0, 1'b0);
        cfg_vld = 1'b1; rx_data = h[31:0];
        tick();
        cfg_vld = 1'b0;
        do_reset();
        check_idle_outputs("midrst");
        send_msg(mk_hdr(5'h12, 64'd0, 1'b0, 1'b0), 64'd0);
        repeat (8) tick();
        chk("midrst_msg", 64'(hs_seen), 64'd1);
        chk("midrst_crd", 64'(crd_seen), 64'd2);

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            d = {$urandom, $urandom};
            case (kind)
                0: send_msg(mk_hdr(5'h12, d, 1'b0, 1'b0), d);
                1: send_msg(mk_hdr(5'h1B, d, 1'b0, 1'b0), d);
                2: send_msg(mk_hdr(($urandom_range(0, 1) != 0) ? 5'h12 : 5'h1B, d, 1'b1, 1'b0), d);
                3: send_msg(mk_hdr(5'h1B, d, 1'b0, 1'b1), d);
                default: begin
                    logic [4:0] op;
                    op = 5'($urandom);
                    while (op == 5'h12 || op == 5'h1B) op = 5'($urandom);
                    send_msg(mk_hdr(op, d, 1'b0, 1'b0), d);
                end
            endcase
            repeat ($urandom_range(0, 2)) begin
                msg_rdy = 1'($urandom_range(0, 1));
                tick();
            end
        end
        rand_mode = 1'b0;
        msg_rdy = 1'b1;
        repeat (40) tick();
        chk("rnd_queue_empty", 64'(exp_hdr_q.size()), 64'd0);
        chk("rnd_crd_total", 64'(crd_seen), 64'(exp_beats));
        chk("rnd_perr", 64'(perr_seen), 64'(exp_perr));
        chk("rnd_oerr", 64'(oerr_seen), 64'(exp_oerr));
        chk("rnd_no_ovf", {63'd0, crd_ovf}, 64'd0);
        chk("rnd_phy_crd", 64'(phy_crd), 64'(CRD_MAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
